// File: rtl/univ_shift_reg.sv
// Universal shift register with parallel load, paced by a programmable tick divider.
// Shifting, loading and dividing all run on clk; the tick acts as a clock enable.
module univ_shift_reg #(
    parameter int WIDTH     = 4,
    parameter int DIV_WIDTH = 25
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [1:0]           mode_i,
    input  logic                 rotate_i,
    input  logic                 ser_i,
    input  logic                 load_i,
    input  logic [WIDTH-1:0]     par_i,
    output logic [WIDTH-1:0]     sr_o,
    output logic                 ser_o,
    output logic                 tick_o
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_RIGHT = 2'b10,
        MODE_HOLD2 = 2'b11
    } mode_t;

    logic [DIV_WIDTH-1:0] r_divCnt;
    logic [WIDTH-1:0]     r_sr;
    logic                 r_ser;

    logic                 w_tick;
    logic [WIDTH-1:0]     w_srNext;
    logic                 w_serNext;
    logic                 w_shiftIn;
    mode_t                w_mode;

    // Comparing with >= lets a lowered div_i end the current period at once.
    assign w_tick = (r_divCnt >= div_i);
    assign w_mode = mode_t'(mode_i);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_divCnt <= '0;
        end else if (w_tick) begin
            r_divCnt <= '0;
        end else begin
            r_divCnt <= r_divCnt + 1'b1;
        end
    end

    always_comb begin
        w_srNext  = r_sr;
        w_serNext = r_ser;
        w_shiftIn = ser_i;
        if (load_i) begin
            w_srNext = par_i;
        end else if (w_tick) begin
            case (w_mode)
                MODE_LEFT: begin
                    w_shiftIn = rotate_i ? r_sr[WIDTH-1] : ser_i;
                    w_srNext  = {r_sr[WIDTH-2:0], w_shiftIn};
                    w_serNext = r_sr[WIDTH-1];
                end
                MODE_RIGHT: begin
                    w_shiftIn = rotate_i ? r_sr[0] : ser_i;
                    w_srNext  = {w_shiftIn, r_sr[WIDTH-1:1]};
                    w_serNext = r_sr[0];
                end
                default: begin
                    w_srNext  = r_sr;
                    w_serNext = r_ser;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr  <= '0;
            r_ser <= 1'b0;
        end else begin
            r_sr  <= w_srNext;
            r_ser <= w_serNext;
        end
    end

    assign sr_o   = r_sr;
    assign ser_o  = r_ser;
    assign tick_o = w_tick;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed scenarios followed by
// randomized traffic, all compared against an arithmetic reference model.
module tb_univ_shift_reg;

    localparam int WIDTH     = 4;
    localparam int DIV_WIDTH = 25;
    localparam int SR_MOD    = 1 << WIDTH;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [DIV_WIDTH-1:0] div_i;
    logic [1:0]           mode_i;
    logic                 rotate_i;
    logic                 ser_i;
    logic                 load_i;
    logic [WIDTH-1:0]     par_i;
    logic [WIDTH-1:0]     sr_o;
    logic                 ser_o;
    logic                 tick_o;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    int mSr    = 0;
    int mSer   = 0;
    int mCnt   = 0;
    bit mKnown = 1'b0;

    univ_shift_reg #(.WIDTH(WIDTH), .DIV_WIDTH(DIV_WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .div_i    (div_i),
        .mode_i   (mode_i),
        .rotate_i (rotate_i),
        .ser_i    (ser_i),
        .load_i   (load_i),
        .par_i    (par_i),
        .sr_o     (sr_o),
        .ser_o    (ser_o),
        .tick_o   (tick_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int modelTick();
        return (mCnt >= int'(div_i)) ? 1 : 0;
    endfunction

    // Advances the reference model by one clock edge using the currently driven inputs.
    task automatic modelEdge();
        int tick;
        int outBit;
        int inBit;
        tick = modelTick();
        if (reset) begin
            mSr    = 0;
            mSer   = 0;
            mCnt   = 0;
            mKnown = 1'b1;
        end else begin
            mCnt = (tick != 0) ? 0 : mCnt + 1;
            if (load_i) begin
                mSr = int'(par_i);
            end else if (tick != 0 && mode_i == 2'b01) begin
                outBit = mSr / (SR_MOD / 2);
                inBit  = rotate_i ? outBit : int'(ser_i);
                mSr    = (mSr * 2 + inBit) % SR_MOD;
                mSer   = outBit;
            end else if (tick != 0 && mode_i == 2'b10) begin
                outBit = mSr % 2;
                inBit  = rotate_i ? outBit : int'(ser_i);
                mSr    = mSr / 2 + inBit * (SR_MOD / 2);
                mSer   = outBit;
            end
        end
    endtask

    task automatic applyStimulus();
        @(negedge clk);
        if (mKnown) checkOutput("tick", {31'b0, tick_o}, modelTick());
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput("sr", {28'b0, sr_o}, mSr);
        checkOutput("ser", {31'b0, ser_o}, mSer);
    endtask

    task automatic setInputs(input logic rst, input int div, input logic [1:0] mode,
                             input logic rot, input logic sin, input logic ld,
                             input logic [WIDTH-1:0] par);
        reset    = rst;
        div_i    = DIV_WIDTH'(div);
        mode_i   = mode;
        rotate_i = rot;
        ser_i    = sin;
        load_i   = ld;
        par_i    = par;
    endtask

    initial begin
        logic [WIDTH-1:0] expLeft  [4];
        logic [WIDTH-1:0] expRight [4];
        logic             expRSer  [4];
        int               savedSer;

        expLeft  = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
        expRight = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
        expRSer  = '{1'b1, 1'b0, 1'b0, 1'b1};

        setInputs(1'b1, 3, 2'b00, 1'b0, 1'b0, 1'b0, '0);
        #2;

        // Reset with div_i = 3, then ticks on cycles 3, 7, 11
        applyStimulus();
        checkOutput("rst_sr", {28'b0, sr_o}, 0);
        checkOutput("rst_ser", {31'b0, ser_o}, 0);
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            checkOutput($sformatf("tick_c%0d", c), {31'b0, tick_o}, (c % 4 == 3) ? 1 : 0);
            applyStimulus();
        end

        // Left shift inserting ones every cycle
        setInputs(1'b1, 0, 2'b00, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus();
        setInputs(1'b0, 0, 2'b01, 1'b0, 1'b1, 1'b0, '0);
        for (int c = 0; c < 4; c++) begin
            applyStimulus();
            checkOutput($sformatf("left_sr%0d", c), {28'b0, sr_o}, {28'b0, expLeft[c]});
            checkOutput($sformatf("left_ser%0d", c), {31'b0, ser_o}, 0);
        end

        // Load 1001 then rotate right
        setInputs(1'b0, 0, 2'b00, 1'b0, 1'b0, 1'b1, 4'b1001);
        applyStimulus();
        setInputs(1'b0, 0, 2'b10, 1'b1, 1'b0, 1'b0, '0);
        for (int c = 0; c < 4; c++) begin
            applyStimulus();
            checkOutput($sformatf("rot_sr%0d", c), {28'b0, sr_o}, {28'b0, expRight[c]});
            checkOutput($sformatf("rot_ser%0d", c), {31'b0, ser_o}, {31'b0, expRSer[c]});
        end

        // Lowering div_i below the running count
        setInputs(1'b1, 7, 2'b00, 1'b0, 1'b0, 1'b0, '0);
        applyStimulus();
        reset = 1'b0;
        for (int c = 0; c < 5; c++) applyStimulus();
        div_i = DIV_WIDTH'(2);
        #1;
        checkOutput("div_lower_tick", {31'b0, tick_o}, 1);
        applyStimulus();
        checkOutput("div_after0", {31'b0, tick_o}, 0);
        applyStimulus();
        checkOutput("div_after1", {31'b0, tick_o}, 0);
        applyStimulus();
        checkOutput("div_after2", {31'b0, tick_o}, 1);

        // Load wins over a ticking left shift
        setInputs(1'b0, 0, 2'b00, 1'b0, 1'b0, 1'b1, 4'b1111);
        applyStimulus();
        setInputs(1'b0, 0, 2'b01, 1'b0, 1'b1, 1'b0, '0);
        applyStimulus();
        setInputs(1'b0, 0, 2'b00, 1'b0, 1'b0, 1'b1, 4'b1111);
        applyStimulus();
        savedSer = mSer;
        setInputs(1'b0, 0, 2'b01, 1'b0, 1'b0, 1'b1, 4'b0110);
        applyStimulus();
        checkOutput("load_prio_sr", {28'b0, sr_o}, 32'h6);
        checkOutput("load_prio_ser", {31'b0, ser_o}, savedSer);

        // Reset in the middle of shifting
        setInputs(1'b0, 0, 2'b01, 1'b0, 1'b1, 1'b0, '0);
        applyStimulus();
        applyStimulus();
        reset = 1'b1;
        applyStimulus();
        checkOutput("midrst_sr", {28'b0, sr_o}, 0);
        checkOutput("midrst_ser", {31'b0, ser_o}, 0);
        reset = 1'b0;
        applyStimulus();
        checkOutput("resume_sr", {28'b0, sr_o}, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            reset    = ($urandom_range(0, 49) == 0);
            load_i   = ($urandom_range(0, 9) == 0);
            mode_i   = 2'($urandom_range(0, 3));
            rotate_i = 1'($urandom);
            ser_i    = 1'($urandom);
            par_i    = WIDTH'($urandom);
            if ($urandom_range(0, 15) == 0) div_i = DIV_WIDTH'($urandom_range(0, 6));
            applyStimulus();
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 4, shift register width in bits (>= 2).
REQ-002 Parameter DIV_WIDTH, default 25, divider counter and div_i width in bits (>= 1).
REQ-003 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, synchronous active-high reset.
REQ-005 Port div_i, input, DIV_WIDTH, tick period minus one (0 gives a tick every cycle).
REQ-006 Port mode_i, input, 2, shift mode: 00 hold, 01 shift left, 10 shift right, 11 hold.
REQ-007 Port rotate_i, input, 1, 1 means rotate (wrap the exiting bit), 0 means insert ser_i.
REQ-008 Port ser_i, input, 1, serial data in.
REQ-009 Port load_i, input, 1, parallel load strobe.
REQ-010 Port par_i, input, WIDTH, parallel load data.
REQ-011 Port sr_o, output, WIDTH, register contents.
REQ-012 Port ser_o, output, 1, bit that exited on the most recent shift.
REQ-013 Port tick_o, output, 1, divider tick (combinational from divider state).

Function
REQ-014 The block SHALL hold an internal DIV_WIDTH-bit counter div_cnt; tick_o SHALL be 1 exactly when div_cnt >= div_i.
REQ-015 On each clk edge, div_cnt SHALL become 0 if tick_o = 1; otherwise it SHALL increment by 1.
  - Tick period = div_i+1 cycles.
  - No wrap-around is possible.
REQ-016 If div_i is lowered below the current div_cnt, tick_o SHALL assert in that same cycle and div_cnt SHALL return to 0.
  - This prevents a 2^DIV_WIDTH-cycle stall.
REQ-017 The divider SHALL run continuously, independent of mode_i, load_i and rotate_i.
REQ-018 Shift actions SHALL occur only on edges where tick_o = 1.
  - No derived or gated clock is permitted.
  - The whole block stays on clk.
REQ-019 Mode 01 with tick_o = 1 SHALL apply sr <= {sr[WIDTH-2:0], in} and ser_o <= sr[WIDTH-1], with in = rotate_i ? sr[WIDTH-1] : ser_i.
REQ-020 Mode 10 with tick_o = 1 SHALL apply sr <= {in, sr[WIDTH-1:1]} and ser_o <= sr[0], with in = rotate_i ? sr[0] : ser_i.
REQ-021 Modes 00 and 11, or tick_o = 0, SHALL leave sr_o and ser_o unchanged.
REQ-022 load_i = 1 SHALL apply sr <= par_i on that edge regardless of tick_o and mode_i.
  - load_i has priority over any shift in the same cycle.
  - ser_o is unchanged.
  - The divider is unaffected.
REQ-023 A shift result SHALL be visible on sr_o in the cycle after the ticking edge (latency 1).
  - There SHALL be no combinational path from any input to sr_o or ser_o.

Reset
REQ-024 reset = 1 at a clk edge SHALL set sr_o = 0, ser_o = 0 and div_cnt = 0.
  - reset overrides load_i and any shift.
REQ-025 After reset, tick_o SHALL equal (div_i == 0) until the first counted edge.
REQ-026 Reset asserted mid-operation SHALL take effect at the next edge, with no partial shift retained.

Verification
REQ-027 Reset with div_i = 3 -> sr_o = 0000 and ser_o = 0; tick_o high in cycles 3, 7, 11 after reset release (cycle 0 = first cycle with reset low).
REQ-028 div_i = 0, mode 01, rotate 0, ser_i = 1 for 4 cycles -> sr_o = 0001, 0011, 0111, 1111; ser_o = 0 throughout.
REQ-029 Load 1001, then div_i = 0, mode 10, rotate 1 for 4 cycles -> sr_o = 1100, 0110, 0011, 1001; ser_o = 1, 0, 0, 1.
REQ-030 div_i = 7, then change div_i to 2 when div_cnt = 5 -> tick_o = 1 in that cycle; next tick 3 cycles later.
REQ-031 load_i = 1 with par_i = 0110 on a ticking cycle in mode 01 with sr = 1111 -> sr_o = 0110 and ser_o unchanged.
REQ-032 Reset asserted while shifting in mode 01 with div_i = 0 -> next cycle sr_o = 0000 and ser_o = 0; shifting resumes one cycle after release.
